// File: rtl/serial_compare_pkg.sv
// Shared types and helpers for the serial compare arbiter.
package serial_compare_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One-hot compare result {lt, eq, gt}
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_NONE = 3'b000;
  localparam cmp_res_t CMP_LT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_GT   = 3'b001;

  // Round-robin pointer following a grant to 'winner'
  function automatic int unsigned rr_next(input int unsigned winner, input int unsigned n_req);
    return (winner + 1) % n_req;
  endfunction

endpackage

// File: rtl/serial_compare_arbiter_bit_compare.sv
// Bit-serial MSB-first magnitude compare: operand shifters, bit counter, sticky result.
// EARLY_EXIT_EN: when defined, done_bit_o also fires on the first differing bit.
module serial_bit_compare
  import serial_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_bit_o,
  output cmp_res_t         result_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmp_res_t         res_q, res_d;
  logic             first_diff_c;

  // Only the first differing bit may set the result
  assign first_diff_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_q == CMP_EQ);

`ifdef EARLY_EXIT_EN
  assign done_bit_o = (cnt_q == '0) || first_diff_c;
`else
  assign done_bit_o = (cnt_q == '0);
`endif

  assign result_o = res_q;

  // Next-state for load / shift steps
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = CNT_W'(WIDTH - 1);
      res_d = CMP_EQ;
    end else if (shift_i) begin
      if (first_diff_c) begin
        res_d = {b_q[WIDTH-1], 1'b0, a_q[WIDTH-1]};
      end
      a_d = a_q << 1;
      b_d = b_q << 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      res_q <= CMP_NONE;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/serial_compare_arbiter.sv
// Round-robin arbiter sharing one bit-serial magnitude comparator among N_REQ requesters.
// EARLY_EXIT_EN: when defined, results return as soon as the first differing bit resolves.
module serial_compare_arbiter
  import serial_compare_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   less_than,
  output logic                   equal_to,
  output logic                   greater_than,
  output logic                   busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d, id_q, id_d;
  logic [ID_W-1:0]  win_c;
  logic             found_c;
  logic [N_REQ-1:0] grant_c;
  logic [WIDTH-1:0] a_sel_c, b_sel_c;
  logic             load_c, shift_c;
  logic             done_bit;
  cmp_res_t         result;

  // Pick first valid requester at or after the pointer, and mux its operands
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    grant_c = '0;
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found_c && req_valid[ID_W'((32'(ptr_q) + k) % N_REQ)]) begin
        found_c = 1'b1;
        win_c   = ID_W'((32'(ptr_q) + k) % N_REQ);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        a_sel_c = req_a[i*WIDTH +: WIDTH];
        b_sel_c = req_b[i*WIDTH +: WIDTH];
      end
    end
    grant_c[win_c] = found_c;
  end

  assign req_ready    = (state_q == IDLE && !reset) ? grant_c : '0;
  assign rsp_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign rsp_id       = id_q;
  assign less_than    = result[2];
  assign equal_to     = result[1];
  assign greater_than = result[0];

  // Next-state and control for the grant / shift / respond sequence
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          load_c  = 1'b1;
          id_d    = win_c;
          ptr_d   = ID_W'(rr_next(32'(win_c), N_REQ));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (done_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and id registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  serial_bit_compare #(.WIDTH(WIDTH)) u_bit_compare (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_c),
    .shift_i    (shift_c),
    .a_i        (a_sel_c),
    .b_i        (b_sel_c),
    .done_bit_o (done_bit),
    .result_o   (result)
  );

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Directed plus randomized bench for serial_compare_arbiter against a behavioural model.
module tb_serial_compare_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic           less_than, equal_to, greater_than;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  always #5 clk = ~clk;

  serial_compare_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .less_than    (less_than),
    .equal_to     (equal_to),
    .greater_than (greater_than),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  endtask

  // Expected {lt, eq, gt} from plain unsigned arithmetic
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a < b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from grant to rsp_valid
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
    for (int k = W - 1; k >= 0; k--) begin
      if (a[k] != b[k]) return W - k + 1;
    end
`endif
    return W + 1;
  endfunction

  function automatic int ref_winner(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  // One full transaction: arbitrate, wait for result, optional stall, handshake
  task automatic serve(input logic [N-1:0] mask, input int stall, input string tag);
    int win;
    int n;
    logic [2:0] exp_res;
    win = ref_winner(mask);
    req_valid = mask;
    drive_ops();
    rsp_ready = (stall == 0);
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << win));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    ptr_m = (win + 1) % N;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_no_grant_shift"}, 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    exp_res = ref_cmp(opa[win], opb[win]);
    check({tag, "_latency"}, 32'(n), 32'(ref_lat(opa[win], opb[win])));
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(win));
    check({tag, "_result"}, 32'({less_than, equal_to, greater_than}), 32'(exp_res));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_stall_id"}, 32'(rsp_id), 32'(win));
      check({tag, "_stall_result"}, 32'({less_than, equal_to, greater_than}), 32'(exp_res));
      check({tag, "_stall_no_grant"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check({tag, "_hs_no_grant"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, "_rsp_clear"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_result", 32'({less_than, equal_to, greater_than}), 32'd0);
    reset = 1'b0;

    // Single requester, A > B
    opa[0] = 4'b1010; opb[0] = 4'b1001;
    serve(4'b0001, 0, "gt_req0");

    // Equal operands
    opa[2] = 4'b0111; opb[2] = 4'b0111;
    serve(4'b0100, 0, "eq_req2");

    // All requesters held high, distinct operands
    opa[0] = 4'd3;  opb[0] = 4'd9;
    opa[1] = 4'd12; opb[1] = 4'd5;
    opa[2] = 4'd6;  opb[2] = 4'd6;
    opa[3] = 4'd15; opb[3] = 4'd14;
    for (int r = 0; r < 5; r++) serve(4'b1111, 0, "rr_all");

    // Stalled response
    opa[1] = 4'b0001; opb[1] = 4'b1000;
    serve(4'b0010, 6, "stall_req1");

    // Reset mid-SHIFT after a grant moves the pointer away from 0
    req_valid = 4'b0010;
    drive_ops();
    rsp_ready = 1'b1;
    #1;
    check("abort_grant", 32'(req_ready), 32'b0010);
    tick();
    tick();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_result", 32'({less_than, equal_to, greater_than}), 32'd0);
    check("abort_rsp_id", 32'(rsp_id), 32'd0);
    reset = 1'b0;
    ptr_m = 0;
    serve(4'b1111, 0, "after_reset");

    // Pointer wrap after requester 3
    serve(4'b1000, 0, "wrap_req3");
    serve(4'b1001, 0, "wrap_req0");

    // Randomized traffic
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = W'($urandom);
        opb[i] = W'($urandom);
      end
      serve(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)), "rand");
    end

    req_valid = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
